seq_arith_unit: RTL and testbench

- Parametrised, handshaked successor of the team's four-op math block: add, sub, multiply and divide on WIDTH-bit unsigned operands.
- Operands are latched on start. Multiply (shift-add) and divide (restoring) iterate one bit per cycle.
- Returns a full double-width product, or quotient plus remainder, with a done pulse and status flags.
- Sits between the register/control logic and the result bus in place of the free-running combinational ALU.

---
 rtl/seq_arith_pkg.sv | 15 +
 rtl/seq_muldiv_core.sv | 94 +++++++++
 rtl/seq_arith_unit.sv | 131 +++++++++++++
 tb/tb_seq_arith_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seq_arith_pkg.sv
// Shared op-codes and FSM encoding for the sequential arithmetic unit.
package seq_arith_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative shift-add multiply / restoring divide datapath, one bit per step.
// Build option SEQ_ARITH_MUL_EARLY_EXIT_EN: multiply ends once the remaining multiplier bits are zero.
module seq_muldiv_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res_lo_nxt,
  output logic [WIDTH-1:0] res_hi_nxt
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // acc: product (mul) or remainder in the low half (div); mcand: shifting
  // multiplicand or fixed divisor; mplier: multiplier, or dividend shifting into quotient.
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;

  logic [WIDTH:0]     rem_sh;
  logic [2*WIDTH-1:0] add_a, add_b;
  logic [2*WIDTH:0]   sum;
  logic               cnt_last;

  // One adder serves both: acc + mcand for mul, rem_sh - divisor for div.
  assign rem_sh = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
  assign add_a  = is_div_q ? {{(WIDTH-1){1'b0}}, rem_sh} : acc_q;
  assign add_b  = is_div_q ? ~mcand_q : mcand_q;
  assign sum    = {1'b0, add_a} + {1'b0, add_b} + {{(2*WIDTH){1'b0}}, is_div_q};

  assign cnt_last = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SEQ_ARITH_MUL_EARLY_EXIT_EN
  assign last = cnt_last || (!is_div_q && (mplier_q[WIDTH-1:1] == '0));
`else
  assign last = cnt_last;
`endif

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    if (load) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, (is_div ? b : a)};
      mplier_d = is_div ? a : b;
      cnt_d    = '0;
      is_div_d = is_div;
    end else if (step) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (is_div_q) begin
        // sum MSB is the no-borrow flag: remainder >= divisor.
        acc_d    = {{WIDTH{1'b0}}, (sum[2*WIDTH] ? sum[WIDTH-1:0] : rem_sh[WIDTH-1:0])};
        mplier_d = {mplier_q[WIDTH-2:0], sum[2*WIDTH]};
      end else begin
        if (mplier_q[0]) acc_d = sum[2*WIDTH-1:0];
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end
    end
  end

  // Results as they will stand after this edge, so the top can register them on the last step.
  assign res_lo_nxt = is_div_q ? mplier_d : acc_d[WIDTH-1:0];
  assign res_hi_nxt = is_div_q ? acc_d[WIDTH-1:0] : acc_d[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
    end
  end

endmodule

// File: rtl/seq_arith_unit.sv
// Handshaked add/sub/mul/div unit: FSM, add/sub, divide-by-zero bypass and held output registers.
// Build option SEQ_ARITH_MUL_EARLY_EXIT_EN shortens multiply latency (see seq_muldiv_core).
module seq_arith_unit
  import seq_arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             carry,
  output logic             div_zero
);

  state_e           state_q, state_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
  logic             carry_q, carry_d, div_zero_q, div_zero_d;

  logic             accept, div_by_zero, single_cycle, core_step, core_last, finish;
  logic [WIDTH:0]   addsub;
  logic [WIDTH-1:0] core_lo, core_hi;

  assign accept       = (state_q == ST_IDLE) && start;
  assign div_by_zero  = (op_q == OP_DIV) && (b_q == '0);
  assign single_cycle = (op_q == OP_ADD) || (op_q == OP_SUB) || div_by_zero;
  assign core_step    = (state_q == ST_CALC) && !single_cycle;
  assign finish       = (state_q == ST_CALC) && (single_cycle || core_last);

  // MSB is carry-out for add and borrow for sub.
  assign addsub = (op_q == OP_SUB) ? ({1'b0, a_q} - {1'b0, b_q})
                                   : ({1'b0, a_q} + {1'b0, b_q});

  seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .step       (core_step),
    .is_div     (op == OP_DIV),
    .a          (a),
    .b          (b),
    .last       (core_last),
    .res_lo_nxt (core_lo),
    .res_hi_nxt (core_hi)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start)  state_d = ST_CALC;
      ST_CALC: if (finish) state_d = ST_FIN;
      ST_FIN:              state_d = ST_IDLE;
      default:             state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_CALC);
    done = (state_q == ST_FIN);
  end

  // Outputs change only on the edge that enters FIN, so they hold through later operations.
  always_comb begin
    result_d   = result_q;
    hi_d       = hi_q;
    carry_d    = carry_q;
    div_zero_d = div_zero_q;
    if (finish) begin
      carry_d    = 1'b0;
      div_zero_d = 1'b0;
      unique case (op_q)
        OP_ADD, OP_SUB: begin
          result_d = addsub[WIDTH-1:0];
          hi_d     = '0;
          carry_d  = addsub[WIDTH];
        end
        default: begin
          if (div_by_zero) begin
            result_d   = '1;
            hi_d       = a_q;
            div_zero_d = 1'b1;
          end else begin
            result_d = core_lo;
            hi_d     = core_hi;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      hi_q       <= '0;
      carry_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
      end
      result_q   <= result_d;
      hi_q       <= hi_d;
      carry_q    <= carry_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign result   = result_q;
  assign hi       = hi_q;
  assign carry    = carry_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Scoreboard bench for seq_arith_unit at WIDTH=16; honours SEQ_ARITH_MUL_EARLY_EXIT_EN if defined.
module tb_seq_arith_unit;
  import seq_arith_pkg::*;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         c;
    logic         dz;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, start, busy, done, carry, div_zero;
  logic [1:0]   op;
  logic [W-1:0] a, b, result, hi;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] prev_res, prev_hi;

  seq_arith_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .hi       (hi),
    .carry    (carry),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int mul_lat(input logic [W-1:0] bv);
`ifdef SEQ_ARITH_MUL_EARLY_EXIT_EN
    int l = 1;
    for (int i = 0; i < W; i++) if (bv[i]) l = i + 1;
    return l;
`else
    return W;
`endif
  endfunction

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t           e;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    e.hi = '0; e.c = 1'b0; e.dz = 1'b0; e.res = '0; e.lat = 1;
    case (o)
      OP_ADD: begin s = {1'b0, av} + {1'b0, bv}; e.res = s[W-1:0]; e.c = s[W]; end
      OP_SUB: begin s = {1'b0, av} - {1'b0, bv}; e.res = s[W-1:0]; e.c = s[W]; end
      OP_MUL: begin
        p = {{W{1'b0}}, av} * {{W{1'b0}}, bv};
        e.res = p[W-1:0]; e.hi = p[2*W-1:W]; e.lat = mul_lat(bv);
      end
      default: begin
        if (bv == '0) begin
          e.res = '1; e.hi = av; e.dz = 1'b1;
        end else begin
          e.res = av / bv; e.hi = av % bv; e.lat = W;
        end
      end
    endcase
    return e;
  endfunction

  // inject_at > 0 pulses an extra start with other operands in that cycle of the operation.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int inject_at);
    exp_t e;
    int   edges;
    int   extra;
    sb.push_back(model(o, av, bv));
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = W'($urandom); b = W'($urandom);
    check("busy_after_accept", busy, 1'b1);
    check("hold_result", result, prev_res);
    check("hold_hi", hi, prev_hi);
    edges = 1;
    while (!done && edges < 200) begin
      if (inject_at != 0 && edges == inject_at) begin
        start = 1'b1; op = OP_MUL; a = 16'h5555; b = 16'h00ff;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    check("done_seen", done, 1'b1);
    if (done) begin
      e = sb.pop_front();
      check("latency", edges - 1, e.lat);
      check("result", result, e.res);
      check("hi", hi, e.hi);
      check("carry", carry, e.c);
      check("div_zero", div_zero, e.dz);
      check("busy_at_done", busy, 1'b0);
      prev_res = e.res;
      prev_hi  = e.hi;
      extra = 0;
      repeat (20) begin
        @(negedge clk);
        if (done) extra++;
      end
      check("extra_done", extra, 0);
      check("idle_busy", busy, 1'b0);
    end
  endtask

  task automatic run_abort(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t dropped;
    sb.push_back(model(OP_DIV, av, bv));
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_result", result, '0);
    check("abort_hi", hi, '0);
    dropped = sb.pop_back();
    prev_res = '0;
    prev_hi  = '0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = OP_ADD; a = '0; b = '0;
    prev_res = '0; prev_hi = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, '0);
    check("rst_hi", hi, '0);
    check("rst_carry", carry, 1'b0);
    check("rst_div_zero", div_zero, 1'b0);

    run_op(OP_ADD, 16'hFFFF, 16'h0001, 0);
    run_op(OP_SUB, 16'd3, 16'd5, 0);
    run_op(OP_MUL, 16'h1234, 16'h0010, 0);
    run_op(OP_DIV, 16'd1000, 16'd7, 0);
    run_op(OP_DIV, 16'hFFFF, 16'h0001, 0);
    run_op(OP_DIV, 16'h1234, 16'h0000, 0);
    run_op(OP_MUL, 16'hFFFF, 16'hFFFF, 0);
    run_op(OP_MUL, 16'hABCD, 16'h0000, 0);
    run_op(OP_MUL, 16'h1234, 16'h0010, 3);
    run_abort(16'd1000, 16'd7);
    run_op(OP_ADD, 16'h00F0, 16'h000F, 0);
    for (int i = 0; i < 8; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = W'($urandom);
      rb = (i % 2 == 0) ? W'($urandom_range(1, 255)) : W'($urandom);
      run_op(ro, ra, rb, 0);
    end
    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
